// File: rtl/sevseg_capture.sv
// rtl/sevseg_capture.sv - seven-segment scan bus decoder, frame capture (SEVSEG_CAPTURE_SYNC_EN adds 2-flop input sync)
module sevseg_capture #(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  i_an,
   input  logic [6:0]  i_seg,
   output logic [31:0] o_digits,
   output logic [7:0]  o_blank,
   output logic [7:0]  o_err,
   output logic        o_frame_valid,
   output logic [7:0]  o_seen
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 2);

   logic [14:0] bus_in;
   logic [14:0] s;
   logic [14:0] p_q;
   logic [7:0]  cnt_q, cnt_d;

   assign bus_in = {i_an, i_seg};

`ifdef SEVSEG_CAPTURE_SYNC_EN
   logic [14:0] sync1_q, sync2_q;

   // two-flop synchronizer, preset to the idle bus (all lines off)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= bus_in;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = bus_in;
`endif

   logic [7:0] s_an;
   logic [6:0] s_seg;
   logic [7:0] an_act;
   logic       an_one;
   logic       capture;
   logic [7:0] cap_oh;

   assign s_an    = s[14:7];
   assign s_seg   = s[6:0];
   assign an_act  = ~s_an;
   assign an_one  = (an_act != 8'd0) && ((an_act & (an_act - 8'd1)) == 8'd0);
   // cnt reaches STABLE_CYCLES-2 only once per stable run, so each dwell fires one event
   assign capture = (s == p_q) && (cnt_q == CAP_CNT);
   assign cap_oh  = (capture && an_one) ? an_act : 8'd0;

   // stability counter: restart on any change, saturate once the run is long enough
   always_comb begin
      cnt_d = cnt_q;
      if (s != p_q) begin
         cnt_d = 8'd0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   logic [3:0] g_nib;
   logic       g_blank;
   logic       g_err;

   // glyph table matching the core's digit encoder (active-low segments)
   always_comb begin
      g_nib   = 4'h0;
      g_blank = 1'b0;
      g_err   = 1'b0;
      case (s_seg)
         7'h01: g_nib = 4'h0;
         7'h4F: g_nib = 4'h1;
         7'h12: g_nib = 4'h2;
         7'h06: g_nib = 4'h3;
         7'h4C: g_nib = 4'h4;
         7'h24: g_nib = 4'h5;
         7'h20: g_nib = 4'h6;
         7'h0F: g_nib = 4'h7;
         7'h00: g_nib = 4'h8;
         7'h04: g_nib = 4'h9;
         7'h08: g_nib = 4'hA;
         7'h60: g_nib = 4'hB;
         7'h31: g_nib = 4'hC;
         7'h42: g_nib = 4'hD;
         7'h30: g_nib = 4'hE;
         7'h38: g_nib = 4'hF;
         7'h7F: g_blank = 1'b1;
         default: g_err = 1'b1;
      endcase
   end

   logic [31:0] sh_nib_q, sh_nib_d;
   logic [7:0]  sh_blank_q, sh_blank_d;
   logic [7:0]  sh_err_q, sh_err_d;
   logic [7:0]  seen_q, seen_d;
   logic [7:0]  seen_next;
   logic        frame_done;
   logic [31:0] digits_q, digits_d;
   logic [7:0]  blank_q, blank_d;
   logic [7:0]  err_q, err_d;
   logic        fv_q;

   // shadow slot update, seen tracking and frame publication
   always_comb begin
      sh_nib_d   = sh_nib_q;
      sh_blank_d = sh_blank_q;
      sh_err_d   = sh_err_q;
      for (int i = 0; i < 8; i++) begin
         if (cap_oh[i]) begin
            sh_nib_d[4*i +: 4] = g_nib;
            sh_blank_d[i]      = g_blank;
            sh_err_d[i]        = g_err;
         end
      end
      seen_next  = seen_q | cap_oh;
      frame_done = (seen_next == 8'hFF);
      seen_d     = frame_done ? 8'd0 : seen_next;
      digits_d   = digits_q;
      blank_d    = blank_q;
      err_d      = err_q;
      if (frame_done) begin
         // publish from the next-state shadow so a same-cycle capture is included
         digits_d = sh_nib_d;
         blank_d  = sh_blank_d;
         err_d    = sh_err_d;
      end
   end

   // state registers; reset discards any partial frame
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         p_q        <= '1;
         cnt_q      <= 8'd0;
         sh_nib_q   <= 32'd0;
         sh_blank_q <= 8'hFF;
         sh_err_q   <= 8'd0;
         seen_q     <= 8'd0;
         digits_q   <= 32'd0;
         blank_q    <= 8'hFF;
         err_q      <= 8'd0;
         fv_q       <= 1'b0;
      end else begin
         p_q        <= s;
         cnt_q      <= cnt_d;
         sh_nib_q   <= sh_nib_d;
         sh_blank_q <= sh_blank_d;
         sh_err_q   <= sh_err_d;
         seen_q     <= seen_d;
         digits_q   <= digits_d;
         blank_q    <= blank_d;
         err_q      <= err_d;
         fv_q       <= frame_done;
      end
   end

   assign o_digits      = digits_q;
   assign o_blank       = blank_q;
   assign o_err         = err_q;
   assign o_frame_valid = fv_q;
   assign o_seen        = seen_q;

endmodule
